// File: rtl/sd_block_writer.sv
// Stages a byte stream into 512-byte blocks and writes each full block through the sd_controller
// write handshake. Optional pad-and-flush of a partial block when SD_WRITER_FLUSH_EN is defined.
module sd_block_writer #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned ADDR_STEP   = 1,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic        clk_25mhz,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_address,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
`ifdef SD_WRITER_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        ctrl_ready,
    input  logic        ctrl_ready_for_next_byte,
    output logic        ctrl_wr,
    output logic [31:0] ctrl_address,
    output logic [7:0]  ctrl_din,
    output logic        done,
    output logic        busy
);

    localparam int unsigned AW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_RDY,
        S_ISSUE,
        S_SEND,
        S_FINISH
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] count, count_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic          pad_q, pad_nxt;
    logic          load_pending, load_nxt;
    logic          rfnb_prev;
    logic          in_ready_nxt;
    logic          ctrl_wr_nxt;
    logic [31:0]   addr_nxt;
    logic [7:0]    din_nxt;
    logic          done_nxt;
    logic          busy_nxt;

    logic [7:0]    buf_mem [BLOCK_BYTES];
    logic          buf_we;
    logic [7:0]    buf_wdata;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    logic          accept;
    logic          rfnb_fall;
    logic          flush_req;

`ifdef SD_WRITER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign accept    = in_valid & in_ready;
    assign rfnb_fall = rfnb_prev & ~ctrl_ready_for_next_byte;

    // Read one byte ahead of the controller so the next byte is ready when a fall is seen
    assign rd_addr = (state == S_ISSUE || state == S_SEND) ? idx + AW'(1) : '0;

    always_ff @(posedge clk_25mhz) begin
        if (buf_we) begin
            buf_mem[count] <= buf_wdata;
        end
        rd_data <= buf_mem[rd_addr];
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state        <= S_IDLE;
            count        <= '0;
            idx          <= '0;
            pad_q        <= 1'b0;
            load_pending <= 1'b0;
            rfnb_prev    <= 1'b0;
            in_ready     <= 1'b0;
            ctrl_wr      <= 1'b0;
            ctrl_address <= 32'h0;
            ctrl_din     <= 8'hFF;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            idx          <= idx_nxt;
            pad_q        <= pad_nxt;
            load_pending <= load_nxt;
            rfnb_prev    <= ctrl_ready_for_next_byte;
            in_ready     <= in_ready_nxt;
            ctrl_wr      <= ctrl_wr_nxt;
            ctrl_address <= addr_nxt;
            ctrl_din     <= din_nxt;
            done         <= done_nxt;
            busy         <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        idx_nxt      = idx;
        pad_nxt      = pad_q;
        load_nxt     = 1'b0;
        in_ready_nxt = in_ready;
        ctrl_wr_nxt  = 1'b0;
        addr_nxt     = ctrl_address;
        din_nxt      = ctrl_din;
        done_nxt     = 1'b0;
        buf_we       = 1'b0;
        buf_wdata    = in_data;

        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nxt     = start_address;
                    count_nxt    = '0;
                    pad_nxt      = 1'b0;
                    in_ready_nxt = 1'b1;
                    state_nxt    = S_FILL;
                end
            end

            S_FILL: begin
                if (pad_q) begin
                    buf_we    = 1'b1;
                    buf_wdata = PAD_BYTE;
                    if (count == LAST_IDX) begin
                        count_nxt = '0;
                        pad_nxt   = 1'b0;
                        state_nxt = S_WAIT_RDY;
                    end else begin
                        count_nxt = count + AW'(1);
                    end
                end else if (accept) begin
                    buf_we = 1'b1;
                    if (count == LAST_IDX) begin
                        count_nxt    = '0;
                        in_ready_nxt = 1'b0;
                        state_nxt    = S_WAIT_RDY;
                    end else begin
                        count_nxt = count + AW'(1);
                        // Byte in the flush cycle is kept; padding starts after it
                        if (flush_req) begin
                            in_ready_nxt = 1'b0;
                            pad_nxt      = 1'b1;
                        end
                    end
                end else if (flush_req && count != '0) begin
                    in_ready_nxt = 1'b0;
                    pad_nxt      = 1'b1;
                end
            end

            S_WAIT_RDY: begin
                if (ctrl_ready) begin
                    din_nxt   = rd_data;
                    idx_nxt   = '0;
                    state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                ctrl_wr_nxt = 1'b1;
                state_nxt   = S_SEND;
            end

            S_SEND: begin
                if (load_pending) begin
                    din_nxt = rd_data;
                end
                if (rfnb_fall) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_FINISH;
                    end else begin
                        idx_nxt  = idx + AW'(1);
                        load_nxt = 1'b1;
                    end
                end
            end

            S_FINISH: begin
                if (ctrl_ready) begin
                    done_nxt     = 1'b1;
                    addr_nxt     = ctrl_address + 32'(ADDR_STEP);
                    count_nxt    = '0;
                    in_ready_nxt = 1'b1;
                    state_nxt    = S_FILL;
                end
            end

            default: begin
                state_nxt    = S_IDLE;
                in_ready_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt == S_WAIT_RDY) || (state_nxt == S_ISSUE) ||
                   (state_nxt == S_SEND)     || (state_nxt == S_FINISH);
    end

endmodule

// File: tb/tb_sd_block_writer.sv
// Directed bench for sd_block_writer with a behavioural sd_controller write-side model.
// Define SD_WRITER_FLUSH_EN to also exercise the pad-and-flush path.
module tb_sd_block_writer;

    localparam int BLOCK = 512;
    localparam int LIMIT = 20000;

    logic        clk_25mhz = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_address;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
`ifdef SD_WRITER_FLUSH_EN
    logic        flush;
`endif
    logic        ctrl_ready;
    logic        ctrl_ready_for_next_byte;
    logic        ctrl_wr;
    logic [31:0] ctrl_address;
    logic [7:0]  ctrl_din;
    logic        done;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int src_stall = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    sd_block_writer dut (
        .clk_25mhz               (clk_25mhz),
        .rst                     (rst),
        .start                   (start),
        .start_address           (start_address),
        .in_data                 (in_data),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
`ifdef SD_WRITER_FLUSH_EN
        .flush                   (flush),
`endif
        .ctrl_ready              (ctrl_ready),
        .ctrl_ready_for_next_byte(ctrl_ready_for_next_byte),
        .ctrl_wr                 (ctrl_wr),
        .ctrl_address            (ctrl_address),
        .ctrl_din                (ctrl_din),
        .done                    (done),
        .busy                    (busy)
    );

    // Controller model: idle/ready until ctrl_wr, then 512 rfnb pulses (2 high, 3 low), then programming delay
    logic        ready_en;
    logic        m_busy;
    int          m_t, m_bytes, m_prog;
    logic [31:0] wr_q[$];
    logic [7:0]  cap_q[$];
    int          done_cnt;
    int          in_ready_busy = 0;

    assign ctrl_ready = ready_en & ~m_busy;

    always @(negedge clk_25mhz) begin
        if (rst) begin
            m_busy = 1'b0;
            m_t = 0;
            m_bytes = 0;
            m_prog = 0;
            ctrl_ready_for_next_byte = 1'b0;
            wr_q.delete();
            cap_q.delete();
            done_cnt = 0;
        end else begin
            if (done) done_cnt++;
            if (busy && in_ready) in_ready_busy++;
            if (!m_busy) begin
                if (ctrl_wr) begin
                    m_busy = 1'b1;
                    m_t = 0;
                    m_bytes = 0;
                    m_prog = 0;
                    wr_q.push_back(ctrl_address);
                end
            end else if (m_bytes < BLOCK) begin
                if (m_t == 0) begin
                    ctrl_ready_for_next_byte = 1'b1;
                end else if (m_t == 2) begin
                    cap_q.push_back(ctrl_din);
                    ctrl_ready_for_next_byte = 1'b0;
                    m_bytes++;
                end
                m_t = (m_t == 4) ? 0 : m_t + 1;
            end else if (m_prog < 8) begin
                m_prog++;
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int kind, input int i);
        case (kind)
            0:       return 8'(i);
            1:       return 8'(i * 3 + 7);
            2:       return 8'hA5;
            default: return (i < 10) ? 8'hA5 : 8'h00;
        endcase
    endfunction

    task automatic send_bytes(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            int t;
            in_data  = gen(kind, i);
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < LIMIT) begin
                @(negedge clk_25mhz);
                t++;
            end
            if (t >= LIMIT) src_stall++;
            @(negedge clk_25mhz);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input string tag);
        int t;
        t = 0;
        while (done_cnt < n && t < LIMIT) begin
            @(negedge clk_25mhz);
            t++;
        end
        check(tag, 32'(done_cnt), 32'(n));
    endtask

    task automatic check_block(input int first, input int kind, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < BLOCK; i++) begin
            if (first + i >= cap_q.size() || cap_q[first + i] !== gen(kind, i)) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_25mhz);
        rst = 1'b1;
        @(negedge clk_25mhz);
        @(negedge clk_25mhz);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] a);
        start = 1'b1;
        start_address = a;
        @(negedge clk_25mhz);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_address = 32'h0;
        in_data = 8'h00;
        in_valid = 1'b0;
        ready_en = 1'b1;
`ifdef SD_WRITER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(negedge clk_25mhz);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ctrl_wr", 32'(ctrl_wr), 32'd0);
        check("rst_ctrl_address", ctrl_address, 32'h0);
        check("rst_ctrl_din", 32'(ctrl_din), 32'hFF);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk_25mhz);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Single block at 0x100
        pulse_start(32'h100);
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_address", ctrl_address, 32'h100);
        send_bytes(BLOCK, 0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        wait_done(1, "blk1_done");
        check("blk1_wr_count", 32'(wr_q.size()), 32'd1);
        check("blk1_addr", wr_q[0], 32'h100);
        check("blk1_bytes", 32'(cap_q.size()), 32'd512);
        check_block(0, 0, "blk1_data");
        check("blk1_next_addr", ctrl_address, 32'h101);

        // Two back-to-back blocks
        send_bytes(2 * BLOCK, 0);
        wait_done(3, "b2b_done");
        check("b2b_wr_count", 32'(wr_q.size()), 32'd3);
        check("b2b_addr1", wr_q[1], 32'h101);
        check("b2b_addr2", wr_q[2], 32'h102);
        check_block(512, 0, "b2b_data1");
        check_block(1024, 0, "b2b_data2");
        check("b2b_in_ready_busy", 32'(in_ready_busy), 32'd0);

        // Controller held not-ready after fill
        ready_en = 1'b0;
        send_bytes(BLOCK, 1);
        check("hold_busy", 32'(busy), 32'd1);
        begin
            int wr_seen;
            wr_seen = 0;
            repeat (100) begin
                @(negedge clk_25mhz);
                if (ctrl_wr) wr_seen++;
            end
            check("hold_no_wr", 32'(wr_seen), 32'd0);
        end
        ready_en = 1'b1;
        @(negedge clk_25mhz);
        check("hold_wr_lat1", 32'(ctrl_wr), 32'd0);
        @(negedge clk_25mhz);
        check("hold_wr_lat2", 32'(ctrl_wr), 32'd1);
        @(negedge clk_25mhz);
        check("hold_wr_one_cycle", 32'(ctrl_wr), 32'd0);
        wait_done(4, "hold_done");
        check("hold_addr", wr_q[3], 32'h103);
        check_block(1536, 1, "hold_data");
        check("hold_in_ready_busy", 32'(in_ready_busy), 32'd0);

        // Reset mid-write, then a clean block at 0x200
        send_bytes(BLOCK, 0);
        begin
            int t;
            t = 0;
            while (cap_q.size() < 2048 + 200 && t < LIMIT) begin
                @(negedge clk_25mhz);
                t++;
            end
            check("mid_reached_200", 32'(cap_q.size() >= 2048 + 200), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk_25mhz);
        check("mid_rst_ctrl_wr", 32'(ctrl_wr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_addr", ctrl_address, 32'h0);
        @(negedge clk_25mhz);
        rst = 1'b0;
        @(negedge clk_25mhz);
        pulse_start(32'h200);
        send_bytes(BLOCK, 1);
        wait_done(1, "restart_done");
        check("restart_wr_count", 32'(wr_q.size()), 32'd1);
        check("restart_addr", wr_q[0], 32'h200);
        check("restart_bytes", 32'(cap_q.size()), 32'd512);
        check_block(0, 1, "restart_data");

        // Address wrap, and start ignored outside IDLE
        do_reset();
        pulse_start(32'hFFFF_FFFF);
        check("wrap_start_addr", ctrl_address, 32'hFFFF_FFFF);
        pulse_start(32'h55);
        check("start_ignored", ctrl_address, 32'hFFFF_FFFF);
        send_bytes(2 * BLOCK, 0);
        wait_done(2, "wrap_done");
        check("wrap_addr0", wr_q[0], 32'hFFFF_FFFF);
        check("wrap_addr1", wr_q[1], 32'h0);
        check("wrap_next_addr", ctrl_address, 32'h1);

`ifdef SD_WRITER_FLUSH_EN
        // Partial block padded on flush
        do_reset();
        pulse_start(32'h300);
        send_bytes(10, 2);
        flush = 1'b1;
        @(negedge clk_25mhz);
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        wait_done(1, "flush_done");
        check("flush_wr_count", 32'(wr_q.size()), 32'd1);
        check("flush_addr", wr_q[0], 32'h300);
        check_block(0, 3, "flush_data");
        repeat (20) @(negedge clk_25mhz);
        check("flush_single_done", 32'(done_cnt), 32'd1);
`endif

        check("source_stalls", 32'(src_stall), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
